// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_RESP = 1'b1
    } state_t;

    localparam int         ADDR_W_DEF = 10;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Byte address falls inside a memory of 2^aw words.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On contention the requester not granted most recently wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dm_arb.sv
// rtl/dm_arb.sv - round-robin arbiter and sequencer for the single-port data memory
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [31:0]       req_addr0,
    input  logic [31:0]       req_addr1,
    input  logic [31:0]       req_wdata0,
    input  logic [31:0]       req_wdata1,
    input  logic [3:0]        req_be0,
    input  logic [3:0]        req_be1,
    output logic [1:0]        resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    state_t      state;
    logic        last;
    logic        pend;
    logic        owner;
    logic        err_q;
    logic [1:0]  grant;
    logic        hs;
    logic        sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        in_range;

    rr_arb2 u_pick (
        .valid (req_valid),
        .last  (last),
        .grant (grant)
    );

    assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign sel       = req_ready[1];
    assign sel_we    = sel ? req_we[1]  : req_we[0];
    assign sel_addr  = sel ? req_addr1  : req_addr0;
    assign sel_wdata = sel ? req_wdata1 : req_wdata0;
    assign sel_be    = sel ? req_be1    : req_be0;
    assign in_range  = addr_in_range(sel_addr, ADDR_W);

    // Out-of-range accesses still handshake but never reach the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (hs && in_range) begin
            mem_en   = 1'b1;
            mem_we   = sel_we;
            mem_addr = sel_addr[ADDR_W+1:2];
            if (sel_we) begin
                mem_wdata = sel_wdata;
                mem_be    = sel_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            pend  <= 1'b0;
            owner <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pend  <= hs;
            err_q <= hs && !in_range;
            state <= IDLE;
            if (hs) begin
                owner <= sel;
                last  <= sel;
                if (in_range && !sel_we) begin
                    state <= RD_RESP;
                end
            end
        end
    end

    // Gating with reset drops a response that is pending when reset arrives.
    assign resp_valid = (pend && !reset) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_err   = pend && err_q && !reset;
    assign resp_rdata = (pend && state == RD_RESP && !reset) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dm_arb.sv
// tb/tb_dm_arb.sv - directed self-checking bench for dm_arb
module tb_dm_arb;
    import dm_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
    logic [3:0]  req_be0, req_be1;
    logic [1:0]  resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int errors = 0;
    int checks = 0;

    dm_arb #(.ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_be0    (req_be0),
        .req_be1    (req_be1),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[1023] = 32'hCAFE0001;
        mem_rdata = 32'd0;
        reset = 1'b1;
        req_valid = 2'b00; req_we = 2'b00;
        req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0;
        req_be0 = 0; req_be1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        chk("rst_ready", {30'd0, req_ready}, 0);
        chk("rst_resp_valid", {30'd0, resp_valid}, 0);
        chk("rst_resp_err", {31'd0, resp_err}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_be", {28'd0, mem_be}, 0);

        // requester 0 full-word write
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01;
        req_addr0 = 32'h10; req_wdata0 = 32'hDEADBEEF; req_be0 = BE_WORD; #1;
        chk("wr_ready", {30'd0, req_ready}, 32'h1);
        chk("wr_mem_en", {31'd0, mem_en}, 1);
        chk("wr_mem_we", {31'd0, mem_we}, 1);
        chk("wr_mem_addr", {22'd0, mem_addr}, 4);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_mem_be", {28'd0, mem_be}, 32'hF);

        // requester 1 reads it back
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b00; req_addr1 = 32'h10; #1;
        chk("wr_resp_valid", {30'd0, resp_valid}, 32'h1);
        chk("wr_resp_err", {31'd0, resp_err}, 0);
        chk("rd_ready", {30'd0, req_ready}, 32'h2);
        chk("rd_mem_en", {31'd0, mem_en}, 1);
        chk("rd_mem_we", {31'd0, mem_we}, 0);
        chk("rd_mem_addr", {22'd0, mem_addr}, 4);

        // RD_RESP cycle with both requesters already asking to write
        @(negedge clk);
        req_valid = 2'b11; req_we = 2'b11;
        req_addr0 = 32'h20; req_wdata0 = 32'h11111111; req_be0 = BE_WORD;
        req_addr1 = 32'h24; req_wdata1 = 32'h22222222; req_be1 = BE_WORD; #1;
        chk("rdresp_ready", {30'd0, req_ready}, 0);
        chk("rdresp_valid", {30'd0, resp_valid}, 32'h2);
        chk("rdresp_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rdresp_err", {31'd0, resp_err}, 0);
        chk("rdresp_mem_en", {31'd0, mem_en}, 0);

        // contested writes alternate 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk($sformatf("alt_ready_%0d", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("alt_resp_%0d", k), {30'd0, resp_valid},
                (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
            chk($sformatf("alt_addr_%0d", k), {22'd0, mem_addr}, (k % 2 == 0) ? 32'h8 : 32'h9);
        end
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("alt_resp_last", {30'd0, resp_valid}, 32'h2);

        // out-of-range read
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h1000; #1;
        chk("oor_ready", {30'd0, req_ready}, 32'h1);
        chk("oor_mem_en", {31'd0, mem_en}, 0);
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("oor_resp_valid", {30'd0, resp_valid}, 32'h1);
        chk("oor_resp_err", {31'd0, resp_err}, 1);
        chk("oor_resp_rdata", resp_rdata, 0);

        // highest in-range word
        @(negedge clk);
        req_valid = 2'b01; req_addr0 = 32'hFFC; #1;
        chk("top_mem_en", {31'd0, mem_en}, 1);
        chk("top_mem_addr", {22'd0, mem_addr}, 32'h3FF);
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("top_resp_valid", {30'd0, resp_valid}, 32'h1);
        chk("top_resp_err", {31'd0, resp_err}, 0);
        chk("top_resp_rdata", resp_rdata, 32'hCAFE0001);

        // single-lane write then read-back
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr0 = 32'h10;
        req_wdata0 = 32'h00005500; req_be0 = 4'b0010; #1;
        chk("be_mem_be", {28'd0, mem_be}, 32'h2);
        chk("be_mem_en", {31'd0, mem_en}, 1);
        @(negedge clk);
        req_we = 2'b00; #1;
        chk("be_resp_valid", {30'd0, resp_valid}, 32'h1);
        chk("be_rd_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("be_readback", resp_rdata, 32'hDEAD55EF);
        chk("be_rd_resp_valid", {30'd0, resp_valid}, 32'h1);

        // empty byte-enable write is still acknowledged
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_wdata0 = 32'h0; req_be0 = 4'b0000; #1;
        chk("be0_mem_en", {31'd0, mem_en}, 1);
        chk("be0_mem_be", {28'd0, mem_be}, 0);
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("be0_resp_valid", {30'd0, resp_valid}, 32'h1);

        // reset during RD_RESP drops the response and restores the pointer
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr0 = 32'h20; #1;
        chk("rst_rd_ready", {30'd0, req_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b1; req_valid = 2'b00; #1;
        chk("rst_rd_resp_valid", {30'd0, resp_valid}, 0);
        chk("rst_rd_resp_rdata", resp_rdata, 0);
        @(negedge clk);
        reset = 1'b0; req_valid = 2'b11; req_we = 2'b11;
        req_be0 = BE_WORD; req_be1 = BE_WORD; #1;
        chk("post_rst_ready", {30'd0, req_ready}, 32'h1);
        chk("post_rst_resp", {30'd0, resp_valid}, 0);
        @(negedge clk);
        req_valid = 2'b00; #1;
        chk("post_rst_wr_resp", {30'd0, resp_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
